// File: rtl/pc_sequencer_if.sv
// Decode inputs and PC/RAS status outputs of the program-counter sequencer.
// The driver of the decodes takes the master view; the sequencer takes the slave view.
interface pc_sequencer_if #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic             enable;
    logic             JR_control;
    logic             jal;
    logic             jump;
    logic             branch_taken;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] branch_offset;
    logic [WIDTH-1:0] rs_value;
    logic             clear_flags;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] link_addr;
    logic [CW-1:0]    ras_count;
    logic [WIDTH-1:0] ras_top;
    logic             ras_mismatch;
    logic             ras_overflow;
    logic             ras_underflow;
    logic             illegal;

    modport master (
        output enable, JR_control, jal, jump, branch_taken,
        output jump_target, branch_offset, rs_value, clear_flags,
        input  pc, link_addr, ras_count, ras_top,
        input  ras_mismatch, ras_overflow, ras_underflow, illegal
    );

    modport slave (
        input  enable, JR_control, jal, jump, branch_taken,
        input  jump_target, branch_offset, rs_value, clear_flags,
        output pc, link_addr, ras_count, ras_top,
        output ras_mismatch, ras_overflow, ras_underflow, illegal
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register with next-PC selection and a circular return-address stack that
// checks every jr target against the link address recorded by the matching jal.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    pc_sequencer_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    wp_q, wp_d, wp_prev, wp_next;
    logic [CW-1:0]    count_q, count_d;
    logic             mismatch_q, mismatch_d;
    logic             illegal_q, illegal_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             do_pop, do_push, do_jump, do_branch;
    logic             ras_empty, ras_full;
    logic             clear_en;
    logic [WIDTH-1:0] link;

    assign link      = pc_q + WIDTH'(1);
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CW'(RAS_DEPTH));
    assign wp_prev   = (wp_q == '0) ? PW'(RAS_DEPTH - 1) : wp_q - PW'(1);
    assign wp_next   = (wp_q == PW'(RAS_DEPTH - 1)) ? '0 : wp_q + PW'(1);

    // JR_control outranks jal/jump, so a jal losing to a jr never pushes.
    assign do_pop    = bus.enable & bus.JR_control;
    assign do_push   = bus.enable & ~bus.JR_control & bus.jal;
    assign do_jump   = bus.enable & ~bus.JR_control & (bus.jal | bus.jump);
    assign do_branch = bus.enable & ~bus.JR_control & ~bus.jal & ~bus.jump & bus.branch_taken;
    assign clear_en  = bus.enable & bus.clear_flags;

    always_comb begin
        pc_d        = pc_q;
        wp_d        = wp_q;
        count_d     = count_q;
        mismatch_d  = 1'b0;
        illegal_d   = 1'b0;
        overflow_d  = overflow_q & ~clear_en;
        underflow_d = underflow_q & ~clear_en;

        if (bus.enable) begin
            illegal_d = (bus.JR_control & bus.jal) | (bus.JR_control & bus.jump) |
                        (bus.jal & bus.jump);
            if (do_pop)
                pc_d = bus.rs_value;
            else if (do_jump)
                pc_d = bus.jump_target;
            else if (do_branch)
                pc_d = link + bus.branch_offset;
            else
                pc_d = link;
        end

        if (do_pop) begin
            if (ras_empty) begin
                underflow_d = 1'b1;
            end else begin
                mismatch_d = (ras_mem[wp_prev] != bus.rs_value);
                wp_d       = wp_prev;
                count_d    = count_q - CW'(1);
            end
        end

        // A push while full overwrites the oldest slot, which is the one at wp.
        if (do_push) begin
            wp_d = wp_next;
            if (ras_full)
                overflow_d = 1'b1;
            else
                count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            wp_q        <= '0;
            count_q     <= '0;
            mismatch_q  <= 1'b0;
            illegal_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            wp_q        <= wp_d;
            count_q     <= count_d;
            mismatch_q  <= mismatch_d;
            illegal_q   <= illegal_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack contents carry no reset; ras_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_push)
            ras_mem[wp_q] <= link;
    end

    assign bus.pc            = pc_q;
    assign bus.link_addr     = link;
    assign bus.ras_count     = count_q;
    assign bus.ras_top       = ras_empty ? '0 : ras_mem[wp_prev];
    assign bus.ras_mismatch  = mismatch_q;
    assign bus.ras_overflow  = overflow_q;
    assign bus.ras_underflow = underflow_q;
    assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver updates a queue-based stack model
// and queues the expected state; a monitor compares it after every rising edge.
module tb_pc_sequencer;
    localparam int          WIDTH    = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RST_PC   = 16'h0010;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] link;
        logic [2:0]  cnt;
        logic [15:0] top;
        logic        mm;
        logic        ovf;
        logic        udf;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        exp_q[$];
    logic [15:0] m_ras[$];
    logic [15:0] m_pc;
    logic        m_ovf, m_udf;

    pc_sequencer_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

    pc_sequencer #(.WIDTH(WIDTH), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
        end
    endtask

    function automatic logic [15:0] m_top();
        return (m_ras.size() == 0) ? 16'h0000 : m_ras[$];
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc",            bus.pc,                   e.pc);
            check("link_addr",     bus.link_addr,            e.link);
            check("ras_count",     16'(bus.ras_count),       16'(e.cnt));
            check("ras_top",       bus.ras_top,              e.top);
            check("ras_mismatch",  16'(bus.ras_mismatch),    16'(e.mm));
            check("ras_overflow",  16'(bus.ras_overflow),    16'(e.ovf));
            check("ras_underflow", 16'(bus.ras_underflow),   16'(e.udf));
            check("illegal",       16'(bus.illegal),         16'(e.ill));
        end
    end

    task automatic idle_inputs();
        bus.enable = 1'b0; bus.JR_control = 1'b0; bus.jal = 1'b0; bus.jump = 1'b0;
        bus.branch_taken = 1'b0; bus.clear_flags = 1'b0;
        bus.jump_target = '0; bus.branch_offset = '0; bus.rs_value = '0;
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_ras.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic step(input logic en, input logic jr, input logic jl, input logic jp,
                        input logic br, input logic [15:0] tgt, input logic [15:0] off,
                        input logic [15:0] rs, input logic clr);
        exp_t        e;
        logic [15:0] popped;
        logic        mm, ill, ovf_evt, udf_evt;
        @(negedge clk);
        bus.enable = en; bus.JR_control = jr; bus.jal = jl; bus.jump = jp;
        bus.branch_taken = br; bus.jump_target = tgt; bus.branch_offset = off;
        bus.rs_value = rs; bus.clear_flags = clr;
        mm = 1'b0; ill = 1'b0; ovf_evt = 1'b0; udf_evt = 1'b0;
        if (en) begin
            ill = (int'(jr) + int'(jl) + int'(jp)) > 1;
            if (jr) begin
                if (m_ras.size() == 0) begin
                    udf_evt = 1'b1;
                end else begin
                    popped = m_ras.pop_back();
                    mm = (popped != rs);
                end
                m_pc = rs;
            end else if (jl || jp) begin
                if (jl) begin
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        ovf_evt = 1'b1;
                    end
                    m_ras.push_back(m_pc + 16'd1);
                end
                m_pc = tgt;
            end else if (br) begin
                m_pc = m_pc + 16'd1 + off;
            end else begin
                m_pc = m_pc + 16'd1;
            end
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (ovf_evt) m_ovf = 1'b1;
            if (udf_evt) m_udf = 1'b1;
        end
        e.pc = m_pc; e.link = m_pc + 16'd1; e.cnt = 3'(m_ras.size()); e.top = m_top();
        e.mm = mm; e.ovf = m_ovf; e.udf = m_udf; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic seq()                              ; step(1,0,0,0,0,0,0,0,0);      endtask
    task automatic go(input logic [15:0] t)           ; step(1,0,0,1,0,t,0,0,0);      endtask
    task automatic call(input logic [15:0] t)         ; step(1,0,1,0,0,t,0,0,0);      endtask
    task automatic ret(input logic [15:0] r)          ; step(1,1,0,0,0,0,0,r,0);      endtask
    task automatic clear()                            ; step(1,0,0,0,0,0,0,0,1);      endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_pc",        bus.pc,                 RST_PC);
        check("rst_count",     16'(bus.ras_count),     16'h0);
        check("rst_top",       bus.ras_top,            16'h0);
        check("rst_flags",     16'({bus.ras_mismatch, bus.ras_overflow,
                                    bus.ras_underflow, bus.illegal}), 16'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r16;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_pc",    bus.pc,             RST_PC);
        check("init_count", 16'(bus.ras_count), 16'h0);
        check("init_link",  bus.link_addr,      RST_PC + 16'd1);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) seq();
        reset_mid_cycle();

        go(16'h0020);
        call(16'h0100);
        ret(16'h0021);

        go(16'h0020);
        call(16'h0100);
        ret(16'h0030);
        ret(16'h0031);
        seq();
        seq();
        clear();

        go(16'h0200);
        for (int i = 0; i < 5; i++) call(16'h0300 + 16'(i * 16'h10));
        for (int i = 0; i < 4; i++) ret(m_top());
        ret(16'h0055);
        clear();

        go(16'hFFFE);
        step(1, 0, 0, 0, 1, 0, 16'h0003, 0, 0);
        step(1, 0, 0, 0, 1, 0, 16'hFFF0, 0, 0);
        call(16'h0400);
        step(1, 1, 1, 0, 0, 16'h0500, 0, 16'h0040, 0);
        step(1, 0, 1, 1, 1, 16'h0600, 0, 16'h0000, 0);

        call(16'h0700);
        repeat (3) step(0, 0, 1, 0, 0, 16'h0800, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            logic en, jr, jl, jp, br, clr;
            logic [15:0] rs;
            en  = ($urandom_range(0, 9) != 0);
            jr  = ($urandom_range(0, 4) == 0);
            jl  = ($urandom_range(0, 3) == 0);
            jp  = ($urandom_range(0, 6) == 0);
            br  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 11) == 0);
            r16 = 16'($urandom);
            rs  = ($urandom_range(0, 1) == 1 && m_ras.size() != 0) ? m_top() : r16;
            step(en, jr, jl, jp, br, 16'($urandom), 16'($urandom), rs, clr);
            if (i % 130 == 129) reset_mid_cycle();
        end

        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the processor datapath. It consumes the `JR_control` decode together with jal/jump/branch decodes and holds the PC register that selects the next fetch address. A small return-address stack (RAS) records the link address of every `jal`. Each `jr` pops the stack and checks the popped entry against the register target, giving a call/return consistency monitor for debug.

## Interface
- `WIDTH`, 16: PC/address width in bits. Word-addressed, so next sequential is PC+1.
- `RESET_PC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: number of RAS entries. Must be ≥2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: advance strobe. When low, all state holds and all decode inputs are ignored.
- `JR_control`  in  1: current instruction is `jr`.
- `jal`  in  1: current instruction is jump-and-link.
- `jump`  in  1: current instruction is an unconditional jump.
- `branch_taken`  in  1: conditional branch resolved taken.
- `jump_target`  in  WIDTH: absolute target for `jump`/`jal`.
- `branch_offset`  in  WIDTH: two's-complement word offset for branches.
- `rs_value`  in  WIDTH: register value; this is the `jr` target.
- `clear_flags`  in  1: synchronous clear of the sticky flags.
- `pc`  out  WIDTH: current PC (registered).
- `link_addr`  out  WIDTH: PC+1 (combinational, from `pc`); this is the `jal` write-back value.
- `ras_count`  out  $clog2(RAS_DEPTH+1): valid RAS entries (registered).
- `ras_top`  out  WIDTH: newest RAS entry; 0 when empty.
- `ras_mismatch`  out  1: one-cycle registered pulse after a `jr` whose popped entry ≠ `rs_value`.
- `ras_overflow`  out  1: sticky flag; a push occurred while full.
- `ras_underflow`  out  1: sticky flag; a `jr` occurred while empty.
- `illegal`  out  1: one-cycle registered pulse; more than one of `JR_control`, `jal`, `jump` was asserted with `enable`.

## Operation
- **Next-PC selection** (when `enable` is high), in priority order:
  1. `JR_control` → `rs_value`
  2. `jal` or `jump` → `jump_target`
  3. `branch_taken` → PC+1+`branch_offset`
  4. otherwise → PC+1
- **Arithmetic:** all address arithmetic is modulo 2^WIDTH. PC wraps from all-ones to 0 silently.
- **Conflicting decodes:** `illegal` pulses. The highest-priority source still wins. A `jal` that loses to `JR_control` does not push.
- **RAS storage:** circular buffer with write pointer `wp` and `ras_count`.
- **Push** (`jal` wins): store PC+1 at `wp`, advance `wp` modulo `RAS_DEPTH`, and increment `ras_count` saturating at `RAS_DEPTH`. Push when full overwrites the oldest entry, leaves `ras_count` at `RAS_DEPTH`, and sets `ras_overflow`.
- **Pop** (`JR_control`): if `ras_count` > 0, compare entry `wp-1` with `rs_value` (mismatch → `ras_mismatch` next cycle), retreat `wp`, and decrement `ras_count`. If empty, no pointer change, `ras_underflow` is set and `ras_mismatch` stays low.
- **Push and pop** never occur in the same cycle (priority rule above).
- **Flag clear:** `clear_flags` clears `ras_overflow` and `ras_underflow`. If a new overflow or underflow happens in the same cycle, the set wins.
- **Hold:** with `enable` low, `pc`, the RAS, and the sticky flags hold, and the pulses (`ras_mismatch`, `illegal`) drop to 0.

## Timing
- **Reset** (`rst_n` low, takes effect immediately, asynchronously):
  - `pc`=`RESET_PC`, `ras_count`=0, `wp`=0, `ras_top`=0
  - `ras_mismatch`=0, `ras_overflow`=0, `ras_underflow`=0, `illegal`=0
  - RAS contents need not be cleared.
- **Mid-operation reset:** reset overrides any in-flight push/pop; state after release is exactly the reset state.
- **Latency:** decode inputs sampled at edge N take effect on `pc` and `ras_count` immediately after edge N.
- **Pulses:** `ras_mismatch` and `illegal` are valid for the cycle after edge N only.
- **Combinational outputs:** `link_addr` and `ras_top` follow registered state combinationally, with no extra latency.

## Test plan
- **Reset/sequential:** `RESET_PC`=0x0010, release reset, `enable`=1 with no decodes for 3 cycles → `pc`=0x0010, 0x0011, 0x0012, 0x0013. Assert `rst_n` low mid-cycle → `pc`=0x0010 immediately.
- **Call/return match:** at `pc`=0x0020, `jal` with `jump_target`=0x0100 → `pc`=0x0100, `ras_count`=1, `ras_top`=0x0021. Then `JR_control` with `rs_value`=0x0021 → `pc`=0x0021, `ras_count`=0, `ras_mismatch`=0.
- **Mismatch/underflow:**
  - After one `jal` from 0x0020, `jr` with `rs_value`=0x0030 → `pc`=0x0030, `ras_mismatch` pulses one cycle.
  - A second `jr` → `ras_underflow`=1 and stays set until `clear_flags`.
- **Overflow wrap** (`RAS_DEPTH`=4): five nested `jal` with link addresses A1..A5 → `ras_overflow`=1, `ras_count`=4. Four matching `jr` pop A5, A4, A3, A2 with no mismatch. A fifth `jr` → `ras_underflow`=1.
- **Branch wrap/priority:**
  - `pc`=0xFFFE, `branch_taken` with `branch_offset`=0x0003 → `pc`=0x0002.
  - `JR_control`+`jal` together with `rs_value`=0x0040 → `pc`=0x0040, `illegal` pulses, no push.
- **Hold:** `enable`=0 with `jal` asserted for 3 cycles → `pc`, `ras_count`, and the flags unchanged; `illegal`=0.
